// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Works on operand magnitudes one bit per cycle; signs are applied in a final FIX cycle.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             op_invalid,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_dz;
    logic [WIDTH-1:0]       r_a;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_rem;

    logic                   w_signed;
    logic                   w_n1_neg;
    logic                   w_n2_neg;
    logic [WIDTH-1:0]       w_mag1;
    logic [WIDTH-1:0]       w_mag2;
    logic                   w_accept;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_shift;
    logic                   w_ge;
    logic [WIDTH-1:0]       w_sub;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_remd;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_n1_neg = w_signed && num1[WIDTH-1];
    assign w_n2_neg = w_signed && num2[WIDTH-1];
    assign w_mag1   = w_n1_neg ? -num1 : num1;
    assign w_mag2   = w_n2_neg ? -num2 : num2;

    // A new mult/div may also be taken on the FIX edge so back-to-back ops cost WIDTH+1 cycles.
    assign w_accept = start && !cancel && !op[2] && (r_state == S_IDLE || r_state == S_FIX);

    // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide step: the dividend shifts out of r_acc's low half while quotient bits shift in.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_a});
    assign w_sub   = w_shift[WIDTH-1:0] - r_a;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_dz ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_remd = r_neg_r ? -r_rem : r_rem;

    // NOTE: all state, including the datapath registers, is reset and updated with non-blocking
    // assignments so every read in this block sees the value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_a        <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            op_invalid <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done       <= 1'b0;
            op_invalid <= 1'b0;
            div_zero   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        if (op == OP_MTHI) begin
                            hi <= num1;
                        end else if (op == OP_MTLO) begin
                            lo <= num1;
                        end else if (op[2]) begin
                            op_invalid <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (r_is_div) begin
                            r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= w_mul_next;
                        end
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end

                S_FIX: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (!cancel) begin
                        if (r_is_div) begin
                            hi <= w_remd;
                            lo <= w_quot;
                        end else begin
                            hi <= w_prod[2*WIDTH-1:WIDTH];
                            lo <= w_prod[WIDTH-1:0];
                        end
                        done     <= 1'b1;
                        div_zero <= r_dz;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase

            // Operand capture; later assignments here override the state updates above.
            if (w_accept) begin
                r_state  <= S_RUN;
                busy     <= 1'b1;
                r_cnt    <= CW'(WIDTH);
                r_is_div <= op[1];
                r_neg_q  <= w_n1_neg ^ w_n2_neg;
                r_neg_r  <= w_n1_neg;
                r_dz     <= op[1] && (num2 == '0);
                r_a      <= op[1] ? w_mag2 : w_mag1;
                r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag1 : w_mag2)};
                r_rem    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: a WIDTH=32 instance plus a WIDTH=8 instance.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cancel;
    logic [2:0]   op;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         busy;
    logic         done;
    logic         op_invalid;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    logic         start8;
    logic         cancel8;
    logic [2:0]   op8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         busy8;
    logic         done8;
    logic         inv8;
    logic         dz8;
    logic [7:0]   hi8;
    logic [7:0]   lo8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num1(num1), .num2(num2),
        .cancel(cancel), .busy(busy), .done(done), .op_invalid(op_invalid),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .num1(a8), .num2(b8),
        .cancel(cancel8), .busy(busy8), .done(done8), .op_invalid(inv8),
        .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one mult/div request, then waits for done; lat counts edges after the accepting one.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int bcnt);
        start = 1'b1; op = o; num1 = a; num2 = b;
        tick();
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; num1 = '0; num2 = '0;
        start8 = 1'b0; cancel8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        #12;
        checks++;
        if ({busy, done, op_invalid, div_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, op_invalid, div_zero});
        end
        checks++;
        if ({hi, lo} !== 64'h0) begin
            errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu();
        int lat, bcnt;
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", lat); end
        checks++;
        if (bcnt !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bcnt); end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            errors++; $display("FAIL multu_result: got %h expected FFFFFFFE00000001", {hi, lo});
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_mult();
        int lat, bcnt;
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            errors++; $display("FAIL mult_neg3x7: got %h expected FFFFFFFFFFFFFFEB", {hi, lo});
        end
    endtask

    task automatic test_div();
        int lat, bcnt;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++; $display("FAIL div_neg7by2: got hi:lo %h expected FFFFFFFFFFFFFFFD", {hi, lo});
        end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin
            errors++; $display("FAIL div_minint_by_m1: got hi:lo %h expected 0000000080000000", {hi, lo});
        end
    endtask

    task automatic test_divu();
        int lat, bcnt;
        run_op(3'd3, 32'd100, 32'd0, lat, bcnt);
        checks++;
        if ({div_zero, hi, lo} !== {1'b1, 32'd100, 32'hFFFFFFFF}) begin
            errors++; $display("FAIL divu_by_zero: got dz=%b hi=%h lo=%h expected dz=1 hi=64 lo=FFFFFFFF",
                               div_zero, hi, lo);
        end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 33", lat); end
        tick();
        checks++;
        if (div_zero !== 1'b0) begin errors++; $display("FAIL div_zero_pulse: got %b expected 0", div_zero); end
        run_op(3'd3, 32'd100, 32'd7, lat, bcnt);
        checks++;
        if ({div_zero, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
            errors++; $display("FAIL divu_100by7: got dz=%b hi=%h lo=%h expected dz=0 hi=2 lo=E",
                               div_zero, hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = 3'd4; num1 = 32'h1234;
        tick();
        checks++;
        if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'd14}) begin
            errors++; $display("FAIL mthi: got busy=%b hi=%h lo=%h expected 0 1234 E", busy, hi, lo);
        end
        op = 3'd5; num1 = 32'h5678;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, hi, lo} !== {1'b0, 32'h1234, 32'h5678}) begin
            errors++; $display("FAIL mtlo: got busy=%b hi=%h lo=%h expected 0 1234 5678", busy, hi, lo);
        end
    endtask

    task automatic test_invalid();
        start = 1'b1; op = 3'd6; num1 = 32'hDEAD; num2 = 32'hBEEF;
        tick();
        start = 1'b0;
        checks++;
        if ({op_invalid, busy, hi, lo} !== {2'b10, 32'h1234, 32'h5678}) begin
            errors++; $display("FAIL op_invalid: got inv=%b busy=%b hi=%h lo=%h expected 1 0 1234 5678",
                               op_invalid, busy, hi, lo);
        end
        tick();
        checks++;
        if (op_invalid !== 1'b0) begin errors++; $display("FAIL op_invalid_pulse: got %b expected 0", op_invalid); end
    endtask

    task automatic test_cancel();
        int dones = 0;
        cancel = 1'b1; start = 1'b1; op = 3'd4; num1 = 32'hDEAD;
        tick();
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (hi !== 32'h1234) begin errors++; $display("FAIL cancel_blocks_mthi: got %h expected 1234", hi); end

        start = 1'b1; op = 3'd1; num1 = 32'd5; num2 = 32'd6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
        repeat (40) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL cancel_no_done: got %0d done pulses expected 0", dones); end
        checks++;
        if ({hi, lo} !== {32'h1234, 32'h5678}) begin
            errors++; $display("FAIL cancel_hilo: got %h expected 0000123400005678", {hi, lo});
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        start = 1'b1; op = 3'd1; num1 = 32'd3; num2 = 32'd4;
        tick();
        start = 1'b0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (lat == 5) begin
                start = 1'b1; op = 3'd1; num1 = 32'd100; num2 = 32'd100;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (lat !== 33 || {hi, lo} !== 64'd12) begin
            errors++; $display("FAIL start_while_busy: got lat=%0d hi:lo=%h expected 33 000000000000000C",
                               lat, {hi, lo});
        end
        start = 1'b1; op = 3'd3; num1 = 32'd100; num2 = 32'd7;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_in_done_cycle: got busy=%b expected 1", busy); end
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 33 || {hi, lo} !== {32'd2, 32'd14}) begin
            errors++; $display("FAIL back_to_back_divu: got lat=%0d hi:lo=%h expected 33 000000020000000E",
                               lat, {hi, lo});
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1; op = 3'd2; num1 = 32'd1000; num2 = 32'd3;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, op_invalid, div_zero, hi, lo} !== '0) begin
            errors++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h expected all 0",
                               busy, done, hi, lo);
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_stays_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_width8();
        int lat = 0;
        start8 = 1'b1; op8 = 3'd3; a8 = 8'hFF; b8 = 8'h10;
        tick();
        start8 = 1'b0;
        while (!done8 && lat < 100) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL w8_latency: got %0d expected 9", lat); end
        checks++;
        if ({hi8, lo8} !== 16'h0F0F) begin
            errors++; $display("FAIL w8_divu: got hi:lo %h expected 0F0F", {hi8, lo8});
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divu();
        test_mthi_mtlo();
        test_invalid();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
